decoder_scan_controller: RTL and testbench

- Sequential stimulus generator sitting directly upstream of decoder_4x16; drives its `inputs` and `enabled` pins.
- On a start request it walks the select code from 0 to LAST_INDEX.
  - Each code is held with enable asserted for DWELL_CYCLES clocks.
  - One blanking clock with enable low separates consecutive codes (break-before-make).
- Runs a single pass or continuously; status via busy and a one-cycle done pulse.

---
 rtl/decoder_scan_controller.sv | 149 ++++++++++++++
 tb/tb_decoder_scan_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_controller.sv
// decoder_scan_controller
// Stimulus sequencer for decoder_4x16. On an accepted start it walks the select
// code from 0 to LAST_INDEX. Each code is held with enable high for DWELL_CYCLES
// clocks, and one enable-low blanking clock separates consecutive codes
// (break-before-make). Single-pass or continuous operation; every output is a
// flop, so no input reaches an output combinationally.
module decoder_scan_controller #(
  parameter int unsigned DWELL_CYCLES = 4,   // 1..255
  parameter int unsigned LAST_INDEX   = 15   // 0..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       continuous,
  output logic [3:0] inputs,
  output logic       enabled,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] DWELL_RELOAD = 8'(DWELL_CYCLES - 1);
  localparam logic [3:0] LAST_CODE    = 4'(LAST_INDEX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_BLANK = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e     state_q;
  logic [3:0] code_q;
  logic       enabled_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] dwell_q;
  logic       cont_q;

  logic [3:0] next_code_d;
  logic       dwell_end_d;
  logic       more_codes_d;

  // Next code in the walk, plus the two decisions taken at the end of a dwell.
  always_comb begin
    next_code_d  = code_q + 4'd1;
    if (code_q == LAST_CODE) begin
      next_code_d = 4'd0;
    end
    dwell_end_d  = (dwell_q == 8'd0);
    // Another code follows unless the last code of a single pass was just driven.
    more_codes_d = (code_q != LAST_CODE) || cont_q;
  end

  // Sequencer: state, dwell counter, latched mode and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      code_q    <= 4'd0;
      enabled_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dwell_q   <= 8'd0;
      cont_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          // stop has priority over a simultaneous start.
          if (start && !stop) begin
            state_q   <= S_DRIVE;
            code_q    <= 4'd0;
            enabled_q <= 1'b1;
            busy_q    <= 1'b1;
            dwell_q   <= DWELL_RELOAD;
            cont_q    <= continuous;
          end else begin
            code_q    <= 4'd0;
            enabled_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end

        S_DRIVE: begin
          if (stop) begin
            state_q   <= S_IDLE;
            code_q    <= 4'd0;
            enabled_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dwell_q   <= 8'd0;
          end else if (!dwell_end_d) begin
            dwell_q <= dwell_q - 8'd1;
          end else if (more_codes_d) begin
            // Code stays on the bus while enable drops for the blank clock.
            state_q   <= S_BLANK;
            enabled_q <= 1'b0;
          end else begin
            // Last code of a single pass goes straight to DONE, no blank.
            state_q   <= S_DONE;
            enabled_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end

        S_BLANK: begin
          if (stop) begin
            state_q   <= S_IDLE;
            code_q    <= 4'd0;
            enabled_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dwell_q   <= 8'd0;
          end else begin
            state_q   <= S_DRIVE;
            code_q    <= next_code_d;
            enabled_q <= 1'b1;
            dwell_q   <= DWELL_RELOAD;
          end
        end

        S_DONE: begin
          // The done pulse always completes; stop and start are not looked at here.
          state_q   <= S_IDLE;
          code_q    <= 4'd0;
          enabled_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          dwell_q   <= 8'd0;
        end

        default: begin
          state_q   <= S_IDLE;
          code_q    <= 4'd0;
          enabled_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          dwell_q   <= 8'd0;
        end
      endcase
    end
  end

  assign inputs  = code_q;
  assign enabled = enabled_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_decoder_scan_controller.sv
// tb_decoder_scan_controller
// Two instances: default parameters (DWELL 4, LAST 15) and a short one
// (DWELL 1, LAST 2). Expected per-cycle outputs are built from the timing
// rules (code n driven for DWELL clocks, then blank or done) and queued as
// {stimulus, expected} records; the run loop drives each record's stimulus,
// clocks once and compares on the falling edge.
module tb_decoder_scan_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_start, a_stop, a_cont;
  logic [3:0] a_inputs;
  logic       a_en, a_busy, a_done;
  logic       b_start, b_stop, b_cont;
  logic [3:0] b_inputs;
  logic       b_en, b_busy, b_done;

  decoder_scan_controller #(.DWELL_CYCLES(4), .LAST_INDEX(15)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .stop(a_stop), .continuous(a_cont),
    .inputs(a_inputs), .enabled(a_en), .busy(a_busy), .done(a_done)
  );

  decoder_scan_controller #(.DWELL_CYCLES(1), .LAST_INDEX(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop), .continuous(b_cont),
    .inputs(b_inputs), .enabled(b_en), .busy(b_busy), .done(b_done)
  );

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       cont;
    logic [3:0] exp_inputs;
    logic       chk_inputs;
    logic       exp_en;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void push(bit st, bit sp, bit ct, int code, bit chk,
                               bit en, bit bz, bit dn);
    vec_t v;
    v.start      = st;
    v.stop       = sp;
    v.cont       = ct;
    v.exp_inputs = 4'(code);
    v.chk_inputs = chk;
    v.exp_en     = en;
    v.exp_busy   = bz;
    v.exp_done   = dn;
    vq.push_back(v);
  endfunction

  // n idle cycles; st/sp let a record present start+stop together.
  function automatic void push_idle(int n, bit st, bit sp);
    for (int i = 0; i < n; i++) push(st, sp, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  // Scan launched by the first record (start=1, continuous=cont); later records
  // drive continuous inverted (must be ignored) and start=hold (must be ignored).
  function automatic void push_scan(int d, int last, bit cont, int total, bit hold);
    int cyc = 0;
    int code = 0;
    while (cyc < total) begin
      for (int k = 0; k < d && cyc < total; k++) begin
        push((cyc == 0) ? 1'b1 : hold, 1'b0, (cyc == 0) ? cont : !cont,
             code, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc++;
      end
      if (cyc >= total) break;
      if (code < last || cont) begin
        push(hold, 1'b0, !cont, code, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc++;
        code = (code == last) ? 0 : code + 1;
      end else begin
        push(hold, 1'b0, !cont, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc++;
        break;
      end
    end
  endfunction

  function automatic void push_stop();
    push(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  // Entered and left on a falling clock edge.
  task automatic run_queue(input string tag, input bit inst);
    vec_t       v;
    int         cyc;
    logic [3:0] g_in;
    logic       g_en, g_bz, g_dn;
    cyc = 0;
    while (vq.size() > 0) begin
      v = vq.pop_front();
      if (inst == 1'b0) begin
        a_start = v.start; a_stop = v.stop; a_cont = v.cont;
      end else begin
        b_start = v.start; b_stop = v.stop; b_cont = v.cont;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (inst == 1'b0) begin
        g_in = a_inputs; g_en = a_en; g_bz = a_busy; g_dn = a_done;
      end else begin
        g_in = b_inputs; g_en = b_en; g_bz = b_busy; g_dn = b_done;
      end
      checks++;
      if ((v.chk_inputs && g_in !== v.exp_inputs) || g_en !== v.exp_en ||
          g_bz !== v.exp_busy || g_dn !== v.exp_done) begin
        errors++;
        $display("FAIL %s cycle %0d: got inputs=%0d enabled=%0b busy=%0b done=%0b, expected inputs=%0d%s enabled=%0b busy=%0b done=%0b",
                 tag, cyc, g_in, g_en, g_bz, g_dn, v.exp_inputs,
                 v.chk_inputs ? "" : "(any)", v.exp_en, v.exp_busy, v.exp_done);
      end else begin
        $display("vec %s cycle %0d: inputs=%0d enabled=%0b busy=%0b done=%0b",
                 tag, cyc, g_in, g_en, g_bz, g_dn);
      end
    end
    a_start = 1'b0; a_stop = 1'b0; a_cont = 1'b0;
    b_start = 1'b0; b_stop = 1'b0; b_cont = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (a_inputs !== 4'd0 || a_en !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0 ||
        b_inputs !== 4'd0 || b_en !== 1'b0 || b_busy !== 1'b0 || b_done !== 1'b0) begin
      errors++;
      $display("FAIL %s: got a={%0d,%0b,%0b,%0b} b={%0d,%0b,%0b,%0b}, expected all zero",
               tag, a_inputs, a_en, a_busy, a_done, b_inputs, b_en, b_busy, b_done);
    end else begin
      $display("chk %s: outputs zero", tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    a_start = 1'b0; a_stop = 1'b0; a_cont = 1'b0;
    b_start = 1'b0; b_stop = 1'b0; b_cont = 1'b0;

    // Reset state, then release on a falling edge.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;
    push_idle(3, 1'b0, 1'b0);
    run_queue("idle_after_reset", 1'b0);

    // Single pass: code n on cycles 1+5n..4+5n, done on cycle 80, idle from 81.
    push_scan(4, 15, 1'b0, 200, 1'b0);
    push_idle(3, 1'b0, 1'b0);
    run_queue("single_pass", 1'b0);

    // Continuous: blank on cycle 80, code 0 again on 81..84, no done in 200 cycles.
    push_scan(4, 15, 1'b1, 200, 1'b0);
    push_stop();
    push_idle(2, 1'b0, 1'b0);
    run_queue("continuous", 1'b0);

    // Stop on cycle 17 (code 3): idle on cycle 18; later start restarts at code 0.
    push_scan(4, 15, 1'b0, 17, 1'b0);
    push_stop();
    push_idle(2, 1'b0, 1'b0);
    push_scan(4, 15, 1'b0, 10, 1'b0);
    run_queue("stop_drive", 1'b0);

    // Stop sampled in BLANK (cycle 5 is the first blank).
    push_stop();
    push_idle(1, 1'b0, 1'b0);
    push_scan(4, 15, 1'b0, 5, 1'b0);
    push_stop();
    push_idle(2, 1'b0, 1'b0);
    run_queue("stop_blank", 1'b0);

    // start and stop together in IDLE: stop wins; start alone then accepted.
    push_idle(1, 1'b1, 1'b1);
    push_scan(4, 15, 1'b0, 6, 1'b0);
    push_stop();
    run_queue("start_stop_idle", 1'b0);

    // Asynchronous reset mid-dwell on code 7 (cycle 37).
    push_scan(4, 15, 1'b0, 37, 1'b0);
    run_queue("pre_async_reset", 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset_immediate");
    @(negedge clk);
    check_zero("async_reset_held");
    rst_n = 1'b1;
    push_idle(4, 1'b0, 1'b0);
    run_queue("after_async_reset", 1'b0);

    // DWELL 1, LAST 2: 0, blank, 1, blank, 2, done on cycle 6; start held
    // throughout is ignored until IDLE, then relaunches one clock later.
    push_scan(1, 2, 1'b0, 50, 1'b1);
    push(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    push_scan(1, 2, 1'b0, 3, 1'b0);
    push_stop();
    push_idle(1, 1'b0, 1'b0);
    run_queue("short_single_hold", 1'b1);

    // DWELL 1, LAST 2 continuous: wrap 2 -> blank -> 0.
    push_scan(1, 2, 1'b1, 14, 1'b0);
    push_stop();
    push_idle(1, 1'b0, 1'b0);
    run_queue("short_continuous", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
